// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected layer engine: FSM encoding,
// activation mode constants, accumulator sizing and saturation bounds.
package nn_pkg;

   // FSM state encoding
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   // Activation modes, sampled with start
   localparam logic ACT_LINEAR = 1'b0;
   localparam logic ACT_RELU   = 1'b1;

   // Full 2*DW product, plus headroom for N_IN products and the bias, plus sign guard
   function automatic int acc_width(input int dw, input int n_in);
      return 2 * dw + $clog2(n_in + 1) + 1;
   endfunction

   // Largest representable output value for a dw-bit signed result
   function automatic longint sat_hi(input int dw);
      return (longint'(1) <<< (dw - 1)) - longint'(1);
   endfunction

   // Smallest representable output value for a dw-bit signed result
   function automatic longint sat_lo(input int dw);
      return -(longint'(1) <<< (dw - 1));
   endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One neuron: accumulator with bias preload, signed MAC, then floor shift,
// optional ReLU and saturation into a held output register.
module nn_mac_lane
   import nn_pkg::*;
#(
   parameter int DW   = 16,
   parameter int FRAC = 8,
   parameter int N_IN = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 mac_en,
   input  logic                 capture,
   input  logic                 act_relu,
   input  logic signed [DW-1:0] bias,
   input  logic signed [DW-1:0] x,
   input  logic signed [DW-1:0] w,
   output logic signed [DW-1:0] y
);

   localparam int ACC_W = acc_width(DW, N_IN);
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(DW));
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(DW));

   logic signed [ACC_W-1:0] acc;
   logic signed [2*DW-1:0]  prod;
   logic signed [ACC_W-1:0] shifted;
   logic signed [ACC_W-1:0] activated;
   logic signed [DW-1:0]    sat_val;

   // Full-precision signed product of the current operand pair
   always_comb begin
      prod = x * w;
   end

   // Accumulator: bias preload on start, MAC when scheduled
   // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         acc <= '0;
      else if (load)
         acc <= ACC_W'(bias) <<< FRAC;
      else if (mac_en)
         acc <= acc + ACC_W'(prod);
   end

   // Output conversion: floor shift, ReLU, then clamp to DW bits
   // NOTE: every branch assigns sat_val, so no latch is inferred.
   always_comb begin
      shifted   = acc >>> FRAC;
      activated = (act_relu && (shifted < 0)) ? '0 : shifted;
      if (activated > SAT_HI)
         sat_val = SAT_HI[DW-1:0];
      else if (activated < SAT_LO)
         sat_val = SAT_LO[DW-1:0];
      else
         sat_val = activated[DW-1:0];
   end

   // Result register, updated only at the end of a completed run
   always_ff @(posedge clk) begin
      if (rst)
         y <= '0;
      else if (capture)
         y <= sat_val;
   end

endmodule

// File: rtl/nn_layer_engine.sv
// Fully-connected layer engine: sequences the shared read index, schedules
// the MAC in every lane and presents all N_OUT results with one pulse.
module nn_layer_engine
   import nn_pkg::*;
#(
   parameter int DW    = 16,
   parameter int FRAC  = 8,
   parameter int N_IN  = 16,
   parameter int N_OUT = 4,
   parameter int IDX_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  act_mode,
   input  logic [N_OUT*DW-1:0]   bias,
   output logic [IDX_W-1:0]      index,
   output logic                  rd_en,
   input  logic [DW-1:0]         x_in,
   input  logic [N_OUT*DW-1:0]   w_in,
   output logic                  ready,
   output logic                  out_valid,
   output logic [N_OUT*DW-1:0]   out
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

   logic [1:0] state;
   logic       act_q;
   logic       load;
   logic       mac_en;
   logic       capture;

   // Handshake and lane control decoded from the current state
   always_comb begin
      ready   = (state == S_IDLE);
      rd_en   = (state == S_RUN);
      load    = (state == S_IDLE) && start;
      // Data for index k arrives one cycle after it is presented, so the
      // first RUN cycle has nothing to accumulate and DRAIN takes the last.
      mac_en  = ((state == S_RUN) && (index != '0)) || (state == S_DRAIN);
      capture = (state == S_FIN);
   end

   // Run sequencer: state, index counter, latched mode and result strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         index     <= '0;
         act_q     <= ACT_LINEAR;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  act_q <= act_mode;
                  index <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (index == LAST_IDX) begin
                  index <= '0;
                  state <= S_DRAIN;
               end else begin
                  index <= index + IDX_W'(1);
               end
            end
            S_DRAIN: state <= S_FIN;
            S_FIN: begin
               out_valid <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // One MAC lane per neuron, all sharing x_in and the control strobes
   for (genvar j = 0; j < N_OUT; j++) begin : g_lane
      nn_mac_lane #(
         .DW   (DW),
         .FRAC (FRAC),
         .N_IN (N_IN)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .load     (load),
         .mac_en   (mac_en),
         .capture  (capture),
         .act_relu (act_q == ACT_RELU),
         .bias     (bias[j*DW +: DW]),
         .x        (x_in),
         .w        (w_in[j*DW +: DW]),
         .y        (out[j*DW +: DW])
      );
   end

endmodule
